// File: rtl/mlp_axis_host_driver_pkg.sv
// mlp_host_pkg: shared FSM state type and default widths for the MLP host driver.
package mlp_host_pkg;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, DONE} host_state_t;
    localparam int DATAW_DEF = 512;
    localparam int IDW_DEF   = 32;
    localparam int USERW_DEF = 32;
    localparam int DESTW_DEF = 32;
    localparam int BUFD_DEF  = 64;
    localparam int CNTW_DEF  = 16;
endpackage

// File: rtl/mlp_axis_host_driver_if.sv
// mlp_axis_host_driver_if: AXI-Stream bundle with master/slave views.
interface mlp_axis_host_driver_if
    import mlp_host_pkg::*;
#(
    parameter int DATAW = DATAW_DEF,
    parameter int IDW   = IDW_DEF,
    parameter int USERW = USERW_DEF,
    parameter int DESTW = DESTW_DEF
);
    logic             tvalid;
    logic             tready;
    logic [DATAW-1:0] tdata;
    logic             tlast;
    logic [IDW-1:0]   tid;
    logic [USERW-1:0] tuser;
    logic [DESTW-1:0] tdest;
    modport master (output tvalid, tdata, tlast, tid, tuser, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tuser, tdest, output tready);
endinterface

// File: rtl/mlp_axis_host_driver_axis_beat_fifo.sv
// axis_beat_fifo: circular first-word-fall-through beat buffer with occupancy count.
module axis_beat_fifo #(
    parameter int DATAW = 512,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DATAW-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [DATAW-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [DATAW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic full, empty, wr_en, rd_en;
    // A full buffer still takes a write when the head is popped in the same cycle.
    always_comb begin
        full     = count_q == FULL;
        empty    = count_q == '0;
        rd_en    = rd_ready && !empty;
        wr_en    = wr_valid && (!full || rd_en);
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign rd_data  = mem_q[rd_ptr_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/mlp_axis_host_driver.sv
// mlp_axis_host_driver: buffers input beats, packetizes them onto AXIS, and counts returned results.
module mlp_axis_host_driver
    import mlp_host_pkg::*;
#(
    parameter int DATAW = DATAW_DEF,
    parameter int IDW   = IDW_DEF,
    parameter int USERW = USERW_DEF,
    parameter int DESTW = DESTW_DEF,
    parameter int BUFD  = BUFD_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [CNTW-1:0]  cfg_tx_beats,
    input  logic [CNTW-1:0]  cfg_pkt_beats,
    input  logic [CNTW-1:0]  cfg_rx_beats,
    input  logic [IDW-1:0]   cfg_tid,
    input  logic [USERW-1:0] cfg_tuser,
    input  logic [DESTW-1:0] cfg_tdest,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [DATAW-1:0] ld_data,
    mlp_axis_host_driver_if.master m,
    mlp_axis_host_driver_if.slave  s,
    mlp_axis_host_driver_if.master res,
    output logic             busy,
    output logic             done,
    output logic             err_cfg,
    output logic [CNTW-1:0]  rx_beat_count,
    output logic [CNTW-1:0]  rx_pkt_count
);
    localparam logic [CNTW-1:0] ONE = CNTW'(1);
    host_state_t state_q, state_d;
    logic [CNTW-1:0] tx_beats_q, tx_beats_d, pkt_beats_q, pkt_beats_d, rx_beats_q, rx_beats_d;
    logic [CNTW-1:0] tx_sent_q, tx_sent_d, bip_q, bip_d, rx_beat_q, rx_beat_d, rx_pkt_q, rx_pkt_d;
    logic [IDW-1:0] tid_q, tid_d;
    logic [USERW-1:0] tuser_q, tuser_d;
    logic [DESTW-1:0] tdest_q, tdest_d;
    logic [DATAW-1:0] res_data_q, res_data_d, fifo_data;
    logic res_valid_q, res_valid_d, res_last_q, res_last_d, err_q, err_d;
    logic fifo_valid, m_fire, rx_fire, start_ok;
    axis_beat_fifo #(.DATAW(DATAW), .DEPTH(BUFD)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (ld_valid),
        .wr_ready (ld_ready),
        .wr_data  (ld_data),
        .rd_valid (fifo_valid),
        .rd_ready (m_fire),
        .rd_data  (fifo_data)
    );
    assign m.tvalid = state_q == SEND && fifo_valid && tx_sent_q < tx_beats_q;
    assign m.tdata  = fifo_data;
    assign m.tlast  = bip_q == pkt_beats_q - ONE || tx_sent_q == tx_beats_q - ONE;
    assign m.tid    = tid_q;
    assign m.tuser  = tuser_q;
    assign m.tdest  = tdest_q;
    assign m_fire   = m.tvalid && m.tready;
    assign s.tready = !res_valid_q || res.tready;
    assign rx_fire  = s.tvalid && s.tready;
    assign res.tvalid = res_valid_q;
    assign res.tdata  = res_data_q;
    assign res.tlast  = res_last_q;
    assign res.tid    = '0;
    assign res.tuser  = '0;
    assign res.tdest  = '0;
    assign start_ok = state_q == IDLE && cfg_start && (cfg_tx_beats != '0 || cfg_rx_beats != '0);
    assign busy          = state_q != IDLE;
    assign done          = state_q == DONE;
    assign err_cfg       = err_q;
    assign rx_beat_count = rx_beat_q;
    assign rx_pkt_count  = rx_pkt_q;
    always_comb begin
        state_d     = state_q;
        tx_beats_d  = tx_beats_q;
        pkt_beats_d = pkt_beats_q;
        rx_beats_d  = rx_beats_q;
        tid_d       = tid_q;
        tuser_d     = tuser_q;
        tdest_d     = tdest_q;
        tx_sent_d   = tx_sent_q;
        bip_d       = bip_q;
        err_d       = 1'b0;
        res_valid_d = rx_fire || (res_valid_q && !res.tready);
        res_data_d  = rx_fire ? s.tdata : res_data_q;
        res_last_d  = rx_fire ? s.tlast : res_last_q;
        // Results are counted in every state; a start clears before counting a same-cycle beat.
        rx_beat_d   = start_ok ? '0 : rx_beat_q;
        rx_pkt_d    = start_ok ? '0 : rx_pkt_q;
        rx_beat_d   = rx_fire && rx_beat_d != '1 ? rx_beat_d + ONE : rx_beat_d;
        rx_pkt_d    = rx_fire && s.tlast && rx_pkt_d != '1 ? rx_pkt_d + ONE : rx_pkt_d;
        case (state_q)
            IDLE: begin
                err_d = cfg_start && !start_ok;
                if (start_ok) begin
                    tx_beats_d  = cfg_tx_beats;
                    pkt_beats_d = cfg_pkt_beats == '0 ? ONE : cfg_pkt_beats;
                    rx_beats_d  = cfg_rx_beats;
                    tid_d       = cfg_tid;
                    tuser_d     = cfg_tuser;
                    tdest_d     = cfg_tdest;
                    tx_sent_d   = '0;
                    bip_d       = '0;
                    state_d     = cfg_tx_beats == '0 ? WAIT_RX : SEND;
                end
            end
            SEND: begin
                if (m_fire) begin
                    tx_sent_d = tx_sent_q + ONE;
                    bip_d     = m.tlast ? '0 : bip_q + ONE;
                    state_d   = tx_sent_q == tx_beats_q - ONE ? WAIT_RX : SEND;
                end
            end
            WAIT_RX: state_d = rx_beat_d >= rx_beats_q ? DONE : WAIT_RX;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_beats_q  <= '0;
            pkt_beats_q <= '0;
            rx_beats_q  <= '0;
            tid_q       <= '0;
            tuser_q     <= '0;
            tdest_q     <= '0;
            tx_sent_q   <= '0;
            bip_q       <= '0;
            rx_beat_q   <= '0;
            rx_pkt_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_beats_q  <= tx_beats_d;
            pkt_beats_q <= pkt_beats_d;
            rx_beats_q  <= rx_beats_d;
            tid_q       <= tid_d;
            tuser_q     <= tuser_d;
            tdest_q     <= tdest_d;
            tx_sent_q   <= tx_sent_d;
            bip_q       <= bip_d;
            rx_beat_q   <= rx_beat_d;
            rx_pkt_q    <= rx_pkt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_mlp_axis_host_driver.sv
// tb_mlp_axis_host_driver: directed self-checking bench for the MLP AXIS host driver.
module tb_mlp_axis_host_driver;
    import mlp_host_pkg::*;
    localparam int DATAW = DATAW_DEF;
    localparam int CNTW  = CNTW_DEF;
    logic clk = 1'b0;
    logic rst;
    logic cfg_start;
    logic [CNTW-1:0] cfg_tx_beats, cfg_pkt_beats, cfg_rx_beats;
    logic [31:0] cfg_tid, cfg_tuser, cfg_tdest;
    logic ld_valid, ld_ready;
    logic [DATAW-1:0] ld_data;
    logic busy, done, err_cfg;
    logic [CNTW-1:0] rx_beat_count, rx_pkt_count;
    int pass_cnt = 0;
    int total_cnt = 0;

    mlp_axis_host_driver_if m_if ();
    mlp_axis_host_driver_if s_if ();
    mlp_axis_host_driver_if r_if ();

    mlp_axis_host_driver dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_tx_beats  (cfg_tx_beats),
        .cfg_pkt_beats (cfg_pkt_beats),
        .cfg_rx_beats  (cfg_rx_beats),
        .cfg_tid       (cfg_tid),
        .cfg_tuser     (cfg_tuser),
        .cfg_tdest     (cfg_tdest),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_data       (ld_data),
        .m             (m_if),
        .s             (s_if),
        .res           (r_if),
        .busy          (busy),
        .done          (done),
        .err_cfg       (err_cfg),
        .rx_beat_count (rx_beat_count),
        .rx_pkt_count  (rx_pkt_count)
    );

    always #5 clk = ~clk;

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = DATAW'(base + i);
        end
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic start(input int tx, input int pkt, input int rx);
        @(negedge clk);
        m_if.tready   = 1'b0;
        cfg_start     = 1'b1;
        cfg_tx_beats  = CNTW'(tx);
        cfg_pkt_beats = CNTW'(pkt);
        cfg_rx_beats  = CNTW'(rx);
        cfg_tid       = 32'd3;
        cfg_tuser     = 32'd5;
        cfg_tdest     = 32'd1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Observes master beats k0..k1-1 of an n-beat transfer whose beat k carries base+k.
    task automatic collect_tx(input int k0, input int k1, input int n, input int pkt,
                              input bit toggle, input int base);
        int k = k0;
        int cyc = 0;
        bit stalled = 1'b0;
        bit exp_last;
        logic [DATAW-1:0] held;
        logic [DATAW-1:0] exp_data;
        while (k < k1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            m_if.tready = toggle ? cyc[0] : 1'b1;
            if (stalled) begin
                total_cnt++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== held)
                    $display("FAIL stall_hold beat %0d: valid=%b data=%0h want valid=1 data=%0h", k, m_if.tvalid, m_if.tdata, held);
                else pass_cnt++;
            end
            stalled = 1'b0;
            if (m_if.tvalid && m_if.tready) begin
                exp_data = DATAW'(base + k);
                exp_last = (k % pkt == pkt - 1) || (k == n - 1);
                total_cnt++;
                if (m_if.tdata !== exp_data || m_if.tlast !== exp_last)
                    $display("FAIL tx_beat %0d: data=%0h last=%b want data=%0h last=%b", k, m_if.tdata, m_if.tlast, exp_data, exp_last);
                else pass_cnt++;
                total_cnt++;
                if ({m_if.tid, m_if.tuser, m_if.tdest} !== {32'd3, 32'd5, 32'd1})
                    $display("FAIL tx_side %0d: tid=%0d tuser=%0d tdest=%0d want 3/5/1", k, m_if.tid, m_if.tuser, m_if.tdest);
                else pass_cnt++;
                k++;
            end else if (m_if.tvalid) begin
                stalled = 1'b1;
                held = m_if.tdata;
            end
        end
        total_cnt++;
        if (k < k1) $display("FAIL tx_timeout: got %0d beats want %0d", k, k1);
        else pass_cnt++;
    endtask

    task automatic send_rx(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = DATAW'(base + i);
            s_if.tlast  = (i == n - 1);
            total_cnt++;
            if (s_if.tready !== 1'b1) $display("FAIL s_tready: got %b want 1", s_if.tready);
            else pass_cnt++;
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        total_cnt++;
        if (r_if.tvalid !== 1'b1 || r_if.tdata !== DATAW'(base + n - 1) || r_if.tlast !== 1'b1)
            $display("FAIL res_out: valid=%b data=%0h last=%b want 1/%0h/1", r_if.tvalid, r_if.tdata, r_if.tlast, base + n - 1);
        else pass_cnt++;
    endtask

    task automatic wait_done();
        int c = 0;
        while (done !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        total_cnt++;
        if (done !== 1'b1) $display("FAIL done_timeout: done=%b want 1", done);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({ld_ready, s_if.tready, m_if.tvalid, r_if.tvalid, busy, done, err_cfg} !== 7'b1100000)
            $display("FAIL reset_flags: got %b want 1100000", {ld_ready, s_if.tready, m_if.tvalid, r_if.tvalid, busy, done, err_cfg});
        else pass_cnt++;
        total_cnt++;
        if (rx_beat_count !== '0 || rx_pkt_count !== '0)
            $display("FAIL reset_counts: beats=%0d pkts=%0d want 0/0", rx_beat_count, rx_pkt_count);
        else pass_cnt++;
    endtask

    task automatic test_basic(input bit toggle);
        load(8, 0);
        start(8, 4, 2);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_send: got %b want 1", busy);
        else pass_cnt++;
        collect_tx(0, 8, 8, 4, toggle, 0);
        send_rx(2, 100);
        total_cnt++;
        if (done !== 1'b1 || rx_beat_count !== 16'd2 || rx_pkt_count !== 16'd1)
            $display("FAIL done_basic: done=%b beats=%0d pkts=%0d want 1/2/1", done, rx_beat_count, rx_pkt_count);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_pulse: done=%b busy=%b want 0/0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_short_pkt();
        load(6, 30);
        start(6, 4, 1);
        collect_tx(0, 6, 6, 4, 1'b0, 30);
        send_rx(1, 300);
        total_cnt++;
        if (done !== 1'b1 || rx_pkt_count !== 16'd1)
            $display("FAIL done_short: done=%b pkts=%0d want 1/1", done, rx_pkt_count);
        else pass_cnt++;
    endtask

    task automatic test_full();
        load(64, 0);
        total_cnt++;
        if (ld_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", ld_ready);
        else pass_cnt++;
        start(65, 0, 0);
        m_if.tready = 1'b1;
        ld_valid = 1'b1;
        ld_data  = DATAW'(64);
        total_cnt++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== DATAW'(0) || m_if.tlast !== 1'b1 || ld_ready !== 1'b0)
            $display("FAIL full_head: valid=%b data=%0h last=%b ready=%b want 1/0/1/0", m_if.tvalid, m_if.tdata, m_if.tlast, ld_ready);
        else pass_cnt++;
        @(negedge clk);
        ld_valid = 1'b0;
        m_if.tready = 1'b0;
        total_cnt++;
        if (ld_ready !== 1'b0) $display("FAIL full_pushpop: ready=%b want 0", ld_ready);
        else pass_cnt++;
        collect_tx(1, 65, 65, 1, 1'b0, 0);
        wait_done();
    endtask

    task automatic test_bad_cfg();
        start(0, 4, 0);
        total_cnt++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) $display("FAIL err_pulse: err=%b busy=%b want 1/0", err_cfg, busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (err_cfg !== 1'b0 || busy !== 1'b0) $display("FAIL err_clear: err=%b busy=%b want 0/0", err_cfg, busy);
        else pass_cnt++;
        start(0, 4, 3);
        total_cnt++;
        if (busy !== 1'b1 || err_cfg !== 1'b0 || m_if.tvalid !== 1'b0)
            $display("FAIL rx_only_state: busy=%b err=%b tvalid=%b want 1/0/0", busy, err_cfg, m_if.tvalid);
        else pass_cnt++;
        send_rx(3, 200);
        total_cnt++;
        if (done !== 1'b1 || rx_beat_count !== 16'd3 || rx_pkt_count !== 16'd1)
            $display("FAIL rx_only_done: done=%b beats=%0d pkts=%0d want 1/3/1", done, rx_beat_count, rx_pkt_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        load(8, 10);
        start(8, 4, 2);
        collect_tx(0, 3, 8, 4, 1'b0, 10);
        @(negedge clk);
        rst = 1'b1;
        m_if.tready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (m_if.tvalid !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1 || rx_beat_count !== '0)
            $display("FAIL mid_reset: tvalid=%b busy=%b ld_ready=%b beats=%0d want 0/0/1/0", m_if.tvalid, busy, ld_ready, rx_beat_count);
        else pass_cnt++;
        load(8, 20);
        start(8, 4, 2);
        collect_tx(0, 8, 8, 4, 1'b0, 20);
        send_rx(2, 400);
        total_cnt++;
        if (done !== 1'b1) $display("FAIL resume_done: got %b want 1", done);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_tx_beats = '0;
        cfg_pkt_beats = '0;
        cfg_rx_beats = '0;
        cfg_tid = '0;
        cfg_tuser = '0;
        cfg_tdest = '0;
        ld_valid = 1'b0;
        ld_data = '0;
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        s_if.tid = '0;
        s_if.tuser = '0;
        s_if.tdest = '0;
        r_if.tready = 1'b1;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_short_pkt();
        test_full();
        test_bad_cfg();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mlp_axis_host_driver.md
Name: mlp_axis_host_driver

Overview:
- Host-side initiator and collector for the two-stage MVM pipeline's AXI-Stream interface.
- Buffers locally loaded input beats, then packetizes them onto an AXI-Stream master port with programmed TID, TUSER and TDEST and with TLAST framing. This port feeds the MVM rx side.
- Accepts result beats from the pipeline's AXI-Stream tx side through a registered slave stage and counts them.
- Signals done once the programmed number of result beats has returned.
- Used as the traffic source and sink around the MLP chain in standalone bring-up and benches.

Parameters:
- DATAW, 512, AXIS data width.
- IDW, 32, TID width.
- USERW, 32, TUSER width.
- DESTW, 32, TDEST width.
- BUFD, 64, input beat buffer depth; power of two, at least 2.
- CNTW, 16, width of all beat and packet counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE
- cfg_tx_beats  in  CNTW  total beats to transmit
- cfg_pkt_beats  in  CNTW  beats per packet; 0 is treated as 1
- cfg_rx_beats  in  CNTW  result beats expected
- cfg_tid  in  IDW  TID value for every transmitted beat
- cfg_tuser  in  USERW  TUSER value for every transmitted beat
- cfg_tdest  in  DESTW  TDEST value for every transmitted beat
- ld_valid  in  1  buffer load valid
- ld_ready  out  1  buffer not full
- ld_data  in  DATAW  buffer load data
- m_tvalid / m_tready / m_tdata / m_tlast / m_tid / m_tuser / m_tdest  out/in/out/out/out/out/out  1/1/DATAW/1/IDW/USERW/DESTW  AXIS master toward MVM rx
- s_tvalid / s_tready / s_tdata / s_tlast  in/out/in/in  1/1/DATAW/1  AXIS slave from MVM tx; TID, TUSER and TDEST are not consumed
- res_valid / res_ready / res_data / res_last  out/in/out/out  1/1/DATAW/1  registered result output
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on completion
- err_cfg  out  1  one-cycle pulse when a start is rejected
- rx_beat_count  out  CNTW  result beats accepted since the last start
- rx_pkt_count  out  CNTW  result beats with TLAST accepted since the last start

Behaviour:
- Reset values: all outputs and counters 0, except ld_ready=1 and s_tready=1. Buffer pointers cleared and buffer contents discarded; FSM goes to IDLE.
- Reset mid-operation: m_tvalid and res_valid are low in the cycle after rst is sampled high.
- Buffer:
  - Circular FIFO of BUFD entries with read and write pointers plus an occupancy count.
  - ld_ready = (count < BUFD). A write occurs when ld_valid && ld_ready.
  - Reads are first-word-fall-through. A beat written in cycle N is visible at the head in cycle N+1.
  - Simultaneous push and pop when full is allowed only if the pop is in the same cycle; ld_ready is still computed from pre-pop count.
  - Pointers wrap modulo BUFD.
  - Loading is permitted in any state.
- FSM states: IDLE, SEND, WAIT_RX, DONE.
  - IDLE, on cfg_start:
    - If cfg_tx_beats == 0 and cfg_rx_beats == 0: pulse err_cfg and stay in IDLE.
    - Otherwise latch all cfg_* fields, clear tx, rx and packet counters, and go to SEND.
    - If cfg_tx_beats == 0, go to WAIT_RX instead.
  - SEND:
    - m_tvalid = buffer not empty and tx_sent < tx_beats.
    - m_tdata = buffer head. m_tid, m_tuser and m_tdest = latched values.
    - m_tlast = (beat_in_pkt == pkt_beats-1) || (tx_sent == tx_beats-1).
    - On m_tvalid && m_tready: pop, increment tx_sent, and advance beat_in_pkt, which wraps to 0 after a TLAST beat.
    - After the final beat's handshake, go to WAIT_RX.
  - WAIT_RX: go to DONE when rx_beat_count == rx_beats, including a beat accepted in the same cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - cfg_start outside IDLE is ignored with no error.
- AXIS rules:
  - Once m_tvalid rises, m_tdata, m_tlast and the sideband signals hold stable until the handshake.
  - m_tvalid never depends combinationally on m_tready.
  - A stalled master (m_tready=0) must not lose or reorder beats.
- Rx stage:
  - Single output register. s_tready = !res_valid || res_ready.
  - On s_tvalid && s_tready: capture data and last, set res_valid, and increment rx_beat_count, plus rx_pkt_count if last.
  - res_valid clears on res_ready when no new beat arrives.
  - Beats are accepted in every state, so early or late results are counted.
  - Counters saturate at 2^CNTW-1.
- Throughput: one beat per cycle sustained on both sides.

Decomposition:
- Shared package mlp_host_pkg:
  - FSM state enum host_state_t.
  - Default width constants, kept consistent with the MLP parameter set.
- One sub-module: axis_beat_fifo, the circular buffer with FWFT head, count, full and empty.
- FSM, packetizer and rx register remain in the top.

Test Plan:
- Load 8 beats (0..7). Start with tx=8, pkt=4, rx=2, tid=3, tuser=5, tdest=1, m_tready=1. Loopback returns 2 beats, the second with TLAST → 8 m beats in order, m_tlast on beats 3 and 7, sideband 3/5/1 on every beat, done pulse the cycle after the 2nd rx beat, rx_pkt_count=1.
- Same stimulus with m_tready toggling every other cycle → m_tdata held stable while stalled, no beats lost or duplicated, total 8 handshakes.
- Start with tx=6 and pkt=4 → TLAST on beats 3 and 5 (short final packet).
- Fill to BUFD=64 → ld_ready=0. Push and pop in the same cycle at full → count stays 64, with no overwrite.
- Start with tx=0, rx=0 → err_cfg pulse, busy stays 0. Start with tx=0, rx=3 → WAIT_RX, then done after 3 rx beats.
- Assert rst in SEND after 3 of 8 beats → m_tvalid=0 next cycle, buffer empty, busy=0. A new load plus start resumes from beat 0.
